// File: rtl/uart_at_sequencer_pkg.sv
// Shared definitions for the AT-command UART sequencer: state encoding,
// ASCII framing constants and the payload size limit.
package uart_at_sequencer_pkg;

   // One encoding shared by the outer sequencer and the byte handshake,
   // so the debug state output can report either without translation.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_ACT  = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_NEXT      = 3'd4,
      ST_GAP       = 3'd5
   } state_t;

   localparam int          MAX_LEN     = 16;
   localparam logic [4:0]  MAX_LEN_W   = 5'd16;

   localparam logic [63:0] AT_SEND     = "AT+SEND=";
   localparam logic [7:0]  ASCII_COMMA = 8'h2C;
   localparam logic [7:0]  ASCII_CR    = 8'h0D;
   localparam logic [7:0]  ASCII_LF    = 8'h0A;
   localparam logic [7:0]  ASCII_ZERO  = 8'h30;
   localparam logic [7:0]  ASCII_ONE   = 8'h31;

   // Character i (0 = 'A') of the fixed "AT+SEND=" prefix.
   function automatic logic [7:0] prefix_char(input logic [2:0] i);
      return AT_SEND[{3'd7 - i, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/uart_at_sequencer_tx_handshake.sv
// Per-byte handshake with the UART transmitter: status synchronizers,
// done-edge detect, DV/byte hold and the per-byte timeout.
//
// Handshake: a one-cycle launch loads launch_data and raises tx_dv; tx_dv
// and tx_byte stay fixed until the synchronized tx_active is seen high,
// then tx_dv drops and the next synchronized rising edge of tx_done ends
// the byte (byte_done pulse). If neither arrives within TIMEOUT_CLKS cycles
// of the launch, tx_dv is dropped and timeout pulses instead. Launches are
// only honoured while the handshake is idle.
module uart_tx_handshake
   import uart_at_sequencer_pkg::*;
#(
   parameter int TIMEOUT_CLKS = 100000
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       launch,
   input  logic [7:0] launch_data,
   input  logic       tx_active,
   input  logic       tx_done,
   output logic       tx_dv,
   output logic [7:0] tx_byte,
   output logic       byte_done,
   output logic       timeout,
   output state_t     hs_state
);

   localparam int            TW         = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CLKS - 1);

   logic [1:0]    act_sync;
   logic [1:0]    done_sync;
   logic          done_prev;
   logic          act_seen;
   logic          done_rise;
   logic [TW-1:0] timer;

   // Two-flop synchronizers for both status lines plus a done history flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_sync  <= '0;
         done_sync <= '0;
         done_prev <= 1'b0;
      end else begin
         act_sync  <= {act_sync[0], tx_active};
         done_sync <= {done_sync[0], tx_done};
         done_prev <= done_sync[1];
      end
   end

   assign act_seen  = act_sync[1];
   assign done_rise = done_sync[1] & ~done_prev;

   // Byte handshake FSM; the timer restarts on every launch and covers both waits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hs_state  <= ST_IDLE;
         tx_dv     <= 1'b0;
         tx_byte   <= 8'h00;
         byte_done <= 1'b0;
         timeout   <= 1'b0;
         timer     <= '0;
      end else begin
         byte_done <= 1'b0;
         timeout   <= 1'b0;
         case (hs_state)
            ST_IDLE: begin
               if (launch) begin
                  tx_dv    <= 1'b1;
                  tx_byte  <= launch_data;
                  timer    <= '0;
                  hs_state <= ST_ISSUE;
               end
            end
            ST_ISSUE, ST_WAIT_ACT: begin
               timer <= timer + 1'b1;
               if (act_seen) begin
                  tx_dv    <= 1'b0;
                  hs_state <= ST_WAIT_DONE;
               end else if (hs_state == ST_WAIT_ACT && timer >= TIMER_LAST) begin
                  tx_dv    <= 1'b0;
                  timeout  <= 1'b1;
                  hs_state <= ST_IDLE;
               end else begin
                  hs_state <= ST_WAIT_ACT;
               end
            end
            ST_WAIT_DONE: begin
               timer <= timer + 1'b1;
               if (done_rise) begin
                  byte_done <= 1'b1;
                  hs_state  <= ST_IDLE;
               end else if (timer >= TIMER_LAST) begin
                  timeout  <= 1'b1;
                  hs_state <= ST_IDLE;
               end
            end
            default: begin
               tx_dv    <= 1'b0;
               hs_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/uart_at_sequencer.sv
// Sends "AT+SEND=<addr>,<len>,<payload>\r\n" from a 16-byte buffer through
// a UART transmitter, one byte per handshake, followed by an idle gap.
module uart_at_sequencer
   import uart_at_sequencer_pkg::*;
#(
   parameter int NODE_ADDR    = 0,
   parameter int GAP_CLKS     = 1000,
   parameter int TIMEOUT_CLKS = 100000
)
(
   input  logic       i_Clock,
   input  logic       i_Rst_n,
   input  logic       i_Start,
   input  logic [4:0] i_Len,
   input  logic       i_Wr_En,
   input  logic [3:0] i_Wr_Addr,
   input  logic [7:0] i_Wr_Data,
   output logic       o_Tx_DV,
   output logic [7:0] o_Tx_Byte,
   input  logic       i_Tx_Active,
   input  logic       i_Tx_Done,
   output logic       o_Busy,
   output logic       o_Msg_Done,
   output logic       o_Err,
   output state_t     o_State
);

   localparam int            GW        = $clog2(GAP_CLKS + 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CLKS - 1);
   localparam logic [7:0]    NODE_CHAR = ASCII_ZERO + 8'(NODE_ADDR);

   logic [7:0]    payload [MAX_LEN];
   state_t        state;
   logic [4:0]    len_q;
   logic [4:0]    idx;
   logic          launch;
   logic [GW-1:0] gap_cnt;
   logic          aborted;
   logic          err_q;

   logic          two_digit;
   logic [4:0]    pay_start;
   logic [4:0]    pay_end;
   logic [4:0]    last_idx;
   logic [3:0]    pay_idx;
   logic [7:0]    msg_byte;

   logic          hs_byte_done;
   logic          hs_timeout;
   state_t        hs_state;

   // Payload buffer: writable only while no message is in flight; not reset.
   always_ff @(posedge i_Clock) begin
      if (i_Wr_En && !o_Busy) begin
         payload[i_Wr_Addr] <= i_Wr_Data;
      end
   end

   // Message layout: prefix 0..7, addr 8, comma 9, length digits from 10,
   // comma, payload, CR, LF.
   always_comb begin
      two_digit = (len_q >= 5'd10);
      pay_start = two_digit ? 5'd13 : 5'd12;
      pay_end   = pay_start + len_q;
      last_idx  = pay_end + 5'd1;
      pay_idx   = 4'(idx - pay_start);
      msg_byte  = ASCII_LF;
      if (idx < 5'd8) begin
         msg_byte = prefix_char(idx[2:0]);
      end else if (idx == 5'd8) begin
         msg_byte = NODE_CHAR;
      end else if (idx == 5'd9) begin
         msg_byte = ASCII_COMMA;
      end else if (idx == 5'd10) begin
         msg_byte = two_digit ? ASCII_ONE : ASCII_ZERO + {3'b000, len_q};
      end else if (idx == 5'd11 && two_digit) begin
         msg_byte = ASCII_ZERO + {3'b000, len_q - 5'd10};
      end else if (idx == pay_start - 5'd1) begin
         msg_byte = ASCII_COMMA;
      end else if (idx < pay_end) begin
         msg_byte = payload[pay_idx];
      end else if (idx == pay_end) begin
         msg_byte = ASCII_CR;
      end
   end

   // Message sequencer: accepts a request, walks the byte index, enforces the gap.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state      <= ST_IDLE;
         len_q      <= '0;
         idx        <= '0;
         launch     <= 1'b0;
         gap_cnt    <= '0;
         aborted    <= 1'b0;
         err_q      <= 1'b0;
         o_Busy     <= 1'b0;
         o_Msg_Done <= 1'b0;
      end else begin
         launch     <= 1'b0;
         err_q      <= 1'b0;
         o_Msg_Done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_Start) begin
                  if (i_Len == 5'd0 || i_Len > MAX_LEN_W) begin
                     err_q <= 1'b1;
                  end else begin
                     len_q   <= i_Len;
                     idx     <= '0;
                     aborted <= 1'b0;
                     launch  <= 1'b1;
                     o_Busy  <= 1'b1;
                     state   <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               if (hs_timeout) begin
                  aborted <= 1'b1;
                  gap_cnt <= '0;
                  state   <= ST_GAP;
               end else if (hs_byte_done) begin
                  state <= ST_NEXT;
               end
            end
            ST_NEXT: begin
               if (idx == last_idx) begin
                  gap_cnt <= '0;
                  state   <= ST_GAP;
               end else begin
                  idx    <= idx + 5'd1;
                  launch <= 1'b1;
                  state  <= ST_ISSUE;
               end
            end
            ST_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  o_Busy     <= 1'b0;
                  o_Msg_Done <= !aborted;
                  state      <= ST_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   uart_tx_handshake #(
      .TIMEOUT_CLKS(TIMEOUT_CLKS)
   ) u_handshake (
      .clk        (i_Clock),
      .rst_n      (i_Rst_n),
      .launch     (launch),
      .launch_data(msg_byte),
      .tx_active  (i_Tx_Active),
      .tx_done    (i_Tx_Done),
      .tx_dv      (o_Tx_DV),
      .tx_byte    (o_Tx_Byte),
      .byte_done  (hs_byte_done),
      .timeout    (hs_timeout),
      .hs_state   (hs_state)
   );

   // Error pulse covers both an illegal length and a byte timeout.
   assign o_Err   = err_q | hs_timeout;
   // While a byte is in flight, report the handshake's finer-grained state.
   assign o_State = (state == ST_ISSUE && hs_state != ST_IDLE) ? hs_state : state;

endmodule

// File: tb/tb_uart_at_sequencer.sv
// Bench for uart_at_sequencer: a transmitter model feeds a byte scoreboard,
// while tasks drive buffer writes and message requests.
module tb_uart_at_sequencer;
   import uart_at_sequencer_pkg::*;

   localparam int NODE    = 0;
   localparam int GAP     = 20;
   localparam int TIMEOUT = 200;

   logic       clk;
   logic       rst_n;
   logic       i_Start;
   logic [4:0] i_Len;
   logic       i_Wr_En;
   logic [3:0] i_Wr_Addr;
   logic [7:0] i_Wr_Data;
   logic       o_Tx_DV;
   logic [7:0] o_Tx_Byte;
   logic       i_Tx_Active;
   logic       i_Tx_Done;
   logic       o_Busy;
   logic       o_Msg_Done;
   logic       o_Err;
   state_t     o_State;

   uart_at_sequencer #(
      .NODE_ADDR   (NODE),
      .GAP_CLKS    (GAP),
      .TIMEOUT_CLKS(TIMEOUT)
   ) dut (
      .i_Clock    (clk),
      .i_Rst_n    (rst_n),
      .i_Start    (i_Start),
      .i_Len      (i_Len),
      .i_Wr_En    (i_Wr_En),
      .i_Wr_Addr  (i_Wr_Addr),
      .i_Wr_Data  (i_Wr_Data),
      .o_Tx_DV    (o_Tx_DV),
      .o_Tx_Byte  (o_Tx_Byte),
      .i_Tx_Active(i_Tx_Active),
      .i_Tx_Done  (i_Tx_Done),
      .o_Busy     (o_Busy),
      .o_Msg_Done (o_Msg_Done),
      .o_Err      (o_Err),
      .o_State    (o_State)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] bufm [16];
   int         n_rx       = 0;
   int         n_done     = 0;
   int         n_err      = 0;
   int         gap_cycles = 0;
   bit         dv_seen    = 0;
   bit         busy_seen  = 0;
   bit         model_en   = 1;
   logic       prev_busy  = 0;

   // Clock and watchdog.
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Output monitor: pulse counters, gap length, completion/busy alignment.
   always @(negedge clk) begin
      if (o_Msg_Done) begin
         n_done++;
         check_eq("busy_low_at_done", o_Busy, 0);
         check_eq("busy_high_before_done", prev_busy, 1);
      end
      if (o_Err) n_err++;
      if (o_State == ST_GAP) gap_cycles++;
      if (o_Tx_DV) dv_seen = 1;
      if (o_Busy) busy_seen = 1;
      prev_busy = o_Busy;
   end

   // Transmitter model: accepts a byte on DV, raises Active after a short delay,
   // then ends the byte with Active low and a Done pulse.
   int         m_state = 0;
   int         m_cnt   = 0;
   logic [7:0] m_byte  = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         m_state     = 0;
         i_Tx_Active = 0;
         i_Tx_Done   = 0;
      end else begin
         case (m_state)
            0: if (model_en && o_Tx_DV) begin
                  m_byte = o_Tx_Byte;
                  n_rx++;
                  if (exp_q.size() == 0) check_eq("tx_byte_extra", exp_q.size(), 1);
                  else check_eq("tx_byte", o_Tx_Byte, exp_q.pop_front());
                  m_cnt   = $urandom_range(1, 3);
                  m_state = 1;
               end
            1: begin
                  if (o_Tx_DV && o_Tx_Byte !== m_byte) check_eq("tx_byte_stable", o_Tx_Byte, m_byte);
                  m_cnt--;
                  if (m_cnt <= 0) begin
                     i_Tx_Active = 1;
                     m_state     = 2;
                  end
               end
            2: begin
                  if (o_Tx_DV && o_Tx_Byte !== m_byte) check_eq("tx_byte_stable", o_Tx_Byte, m_byte);
                  if (!o_Tx_DV) begin
                     m_cnt   = $urandom_range(2, 6);
                     m_state = 3;
                  end
               end
            3: begin
                  m_cnt--;
                  if (m_cnt <= 0) begin
                     i_Tx_Active = 0;
                     i_Tx_Done   = 1;
                     m_cnt       = 2;
                     m_state     = 4;
                  end
               end
            default: begin
                  m_cnt--;
                  if (m_cnt <= 0) begin
                     i_Tx_Done = 0;
                     m_state   = 0;
                  end
               end
         endcase
      end
   end

   task automatic write_buf(input logic [3:0] addr, input logic [7:0] data);
      @(negedge clk);
      i_Wr_En = 1; i_Wr_Addr = addr; i_Wr_Data = data;
      bufm[addr] = data;
      @(negedge clk);
      i_Wr_En = 0;
   endtask

   // Queue the expected line, then issue a one-cycle start.
   task automatic start_msg(input int len, output int exp_len);
      string s;
      s = $sformatf("AT+SEND=%0d,%0d,", NODE, len);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
      for (int i = 0; i < len; i++) exp_q.push_back(bufm[i]);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      exp_len = s.len() + len + 2;
      gap_cycles = 0;
      @(negedge clk);
      i_Start = 1; i_Len = 5'(len);
      @(negedge clk);
      i_Start = 0;
      check_eq("busy_after_start", o_Busy, 1);
   endtask

   task automatic wait_msg_end(input int rx0, input int d0, input int exp_len);
      int budget = 3000;
      while (n_done == d0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      @(negedge clk);
      check_eq("msg_done_count", n_done - d0, 1);
      check_eq("bytes_sent", n_rx - rx0, exp_len);
      check_eq("scoreboard_empty", exp_q.size(), 0);
      check_eq("gap_length", gap_cycles, GAP);
   endtask

   task automatic bad_len(input int len);
      int e0 = n_err;
      dv_seen = 0; busy_seen = 0;
      @(negedge clk);
      i_Start = 1; i_Len = 5'(len);
      @(negedge clk);
      i_Start = 0;
      repeat (10) @(negedge clk);
      check_eq("bad_len_err_pulses", n_err - e0, 1);
      check_eq("bad_len_dv", dv_seen, 0);
      check_eq("bad_len_busy", busy_seen, 0);
   endtask

   initial begin
      int rx0, d0, e0, elen, cnt, budget;
      rst_n = 0; i_Start = 0; i_Len = 0; i_Wr_En = 0; i_Wr_Addr = 0; i_Wr_Data = 0;
      i_Tx_Active = 0; i_Tx_Done = 0;
      repeat (3) @(negedge clk);
      check_eq("rst_tx_dv", o_Tx_DV, 0);
      check_eq("rst_tx_byte", o_Tx_Byte, 0);
      check_eq("rst_busy", o_Busy, 0);
      check_eq("rst_msg_done", o_Msg_Done, 0);
      check_eq("rst_err", o_Err, 0);
      check_eq("rst_state", o_State, ST_IDLE);
      rst_n = 1;
      repeat (2) @(negedge clk);

      // "HI", length 2.
      write_buf(0, "H");
      write_buf(1, "I");
      rx0 = n_rx; d0 = n_done;
      start_msg(2, elen);
      check_eq("hi_line_length", elen, 16);
      wait_msg_end(rx0, d0, elen);

      // Full 16-byte payload 0x00..0x0F.
      for (int i = 0; i < 16; i++) write_buf(4'(i), 8'(i));
      rx0 = n_rx; d0 = n_done;
      start_msg(16, elen);
      wait_msg_end(rx0, d0, elen);

      // Illegal lengths.
      bad_len(0);
      bad_len(17);

      // Transmitter never goes active: timeout, gap, no completion.
      model_en = 0;
      e0 = n_err; d0 = n_done; gap_cycles = 0;
      @(negedge clk);
      i_Start = 1; i_Len = 5'd2;
      @(negedge clk);
      i_Start = 0;
      budget = 20;
      while (!o_Tx_DV && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check_eq("timeout_dv_raised", o_Tx_DV, 1);
      cnt = 0;
      while (!o_Err && cnt <= TIMEOUT + 20) begin
         @(negedge clk);
         cnt++;
      end
      check_eq("timeout_latency", cnt, TIMEOUT);
      check_eq("timeout_dv_low", o_Tx_DV, 0);
      budget = GAP + 20;
      while (o_Busy && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      @(negedge clk);
      check_eq("timeout_gap_length", gap_cycles, GAP);
      check_eq("timeout_busy_low", o_Busy, 0);
      check_eq("timeout_err_pulses", n_err - e0, 1);
      check_eq("timeout_no_msg_done", n_done - d0, 0);
      model_en = 1;

      // Reset while payload byte 3 of a length-5 message is in flight.
      rx0 = n_rx; d0 = n_done;
      start_msg(5, elen);
      budget = 2000;
      while (n_rx - rx0 < 16 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check_eq("reached_payload_byte3", n_rx - rx0, 16);
      #2 rst_n = 0;
      #1;
      check_eq("midrst_tx_dv", o_Tx_DV, 0);
      check_eq("midrst_tx_byte", o_Tx_Byte, 0);
      check_eq("midrst_busy", o_Busy, 0);
      check_eq("midrst_msg_done", o_Msg_Done, 0);
      check_eq("midrst_err", o_Err, 0);
      check_eq("midrst_state", o_State, ST_IDLE);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1;
      repeat (3) @(negedge clk);
      check_eq("midrst_no_msg_done", n_done - d0, 0);
      rx0 = n_rx; d0 = n_done;
      start_msg(2, elen);
      wait_msg_end(rx0, d0, elen);

      // Start and write while busy are both ignored.
      for (int i = 0; i < 4; i++) write_buf(4'(i), 8'($urandom_range(0, 255)));
      rx0 = n_rx; d0 = n_done;
      start_msg(4, elen);
      budget = 2000;
      while (n_rx - rx0 < 5 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      i_Start = 1; i_Len = 5'd3;
      i_Wr_En = 1; i_Wr_Addr = 4'd1; i_Wr_Data = ~bufm[1];
      @(negedge clk);
      i_Start = 0; i_Wr_En = 0;
      wait_msg_end(rx0, d0, elen);
      dv_seen = 0;
      repeat (30) @(negedge clk);
      check_eq("no_queued_start", dv_seen, 0);
      rx0 = n_rx; d0 = n_done;
      start_msg(4, elen);
      wait_msg_end(rx0, d0, elen);

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
      $finish;
   end

endmodule
